// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB widths, tag constants and edge-event encoding
package cdb_arbiter_pkg;

    // Widths and tag space shared with the queue and reservation stations
    localparam int CDB_DATA_W = 32;
    localparam int CDB_ID_W   = 3;
    localparam int CDB_N_REQ  = 4;
    localparam int CDB_CNT_W  = 16;

    // Tag 0 means "no entry"; real queue entries are 1..7
    localparam logic [CDB_ID_W-1:0] CDB_ID_NONE = 3'd0;
    localparam int                  CDB_ID_MIN  = 1;
    localparam int                  CDB_ID_MAX  = 7;

    // What the output stage does on a given clock edge
    typedef enum logic [1:0] {
        CDB_EV_IDLE  = 2'd0,
        CDB_EV_FLUSH = 2'd1,
        CDB_EV_BCAST = 2'd2,
        CDB_EV_DROP  = 2'd3
    } cdb_event_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester offers and CDB broadcast bundle
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ  = CDB_N_REQ,
    parameter int DATA_W = CDB_DATA_W,
    parameter int ID_W   = CDB_ID_W
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ*ID_W-1:0]   req_id;
    logic [N_REQ-1:0]        req_int;

    logic                    cdb_valid;
    logic [DATA_W-1:0]       cdb_data;
    logic [ID_W-1:0]         cdb_id;
    logic                    cdb_int;

    // Execution units and snoopers
    modport master (
        output req_valid, req_data, req_id, req_int,
        input  req_ready,
        input  cdb_valid, cdb_data, cdb_id, cdb_int
    );

    // The arbiter: sole driver of the CDB
    modport slave (
        input  req_valid, req_data, req_id, req_int,
        output req_ready,
        output cdb_valid, cdb_data, cdb_id, cdb_int
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// rtl/cdb_arbiter_rr_pick.sv - combinational rotate-priority picker
module cdb_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx,
    output logic          any
);

    logic [PW-1:0] idx;

    // Scan from the far end back toward ptr so the position closest to ptr wins
    always_comb begin
        any   = 1'b0;
        gidx  = '0;
        idx   = '0;
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                any  = 1'b1;
                gidx = idx;
            end
        end
        if (any) begin
            grant = N'(1) << gidx;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin owner and registered driver of the common data bus
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ  = CDB_N_REQ,
    parameter int DATA_W = CDB_DATA_W,
    parameter int ID_W   = CDB_ID_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    cdb_arbiter_if.slave         bus,
    output logic                 err_zero_id,
    output logic [CDB_CNT_W-1:0] bcast_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [N_REQ-1:0]  pick_grant;
    logic [PW-1:0]     gidx;
    logic              any;

    logic [DATA_W-1:0] g_data;
    logic [ID_W-1:0]   g_id;
    logic              g_int;
    logic [PW-1:0]     rr_next;
    cdb_event_e        ev;

    logic              cdb_valid_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [ID_W-1:0]   cdb_id_q;
    logic              cdb_int_q;

    cdb_arbiter_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .gidx  (gidx),
        .any   (any)
    );

    // Ready depends only on valid, pointer, rst and flush; payload never feeds it
    assign bus.req_ready = (rst || flush) ? '0 : pick_grant;

    assign g_data  = bus.req_data[int'(gidx)*DATA_W +: DATA_W];
    assign g_id    = bus.req_id[int'(gidx)*ID_W +: ID_W];
    assign g_int   = bus.req_int[gidx];
    assign rr_next = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    // Classify this edge; a tag-0 winner is consumed but never reaches the bus
    always_comb begin
        ev = CDB_EV_IDLE;
        if (flush) begin
            ev = CDB_EV_FLUSH;
        end else if (any) begin
            ev = (g_id == ID_W'(CDB_ID_NONE)) ? CDB_EV_DROP : CDB_EV_BCAST;
        end
    end

    // Output stage, priority pointer, sticky tag-0 error and broadcast counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_id_q    <= '0;
            cdb_int_q   <= 1'b0;
            err_zero_id <= 1'b0;
            bcast_cnt   <= '0;
        end else begin
            case (ev)
                CDB_EV_BCAST: begin
                    rr_ptr      <= rr_next;
                    cdb_valid_q <= 1'b1;
                    cdb_data_q  <= g_data;
                    cdb_id_q    <= g_id;
                    cdb_int_q   <= g_int;
                    bcast_cnt   <= bcast_cnt + 1'b1;
                end
                CDB_EV_DROP: begin
                    rr_ptr      <= rr_next;
                    cdb_valid_q <= 1'b0;
                    cdb_data_q  <= '0;
                    cdb_id_q    <= '0;
                    cdb_int_q   <= 1'b0;
                    err_zero_id <= 1'b1;
                end
                CDB_EV_FLUSH: begin
                    rr_ptr      <= '0;
                    cdb_valid_q <= 1'b0;
                    cdb_data_q  <= '0;
                    cdb_id_q    <= '0;
                    cdb_int_q   <= 1'b0;
                end
                default: begin
                    cdb_valid_q <= 1'b0;
                    cdb_data_q  <= '0;
                    cdb_id_q    <= '0;
                    cdb_int_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_id    = cdb_id_q;
    assign bus.cdb_int   = cdb_int_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        err_zero_id;
    logic [15:0] bcast_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) bus ();

    cdb_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .err_zero_id (err_zero_id),
        .bcast_cnt   (bcast_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] d,
                           input logic [2:0] id, input logic in);
        bus.req_valid[i]          = v;
        bus.req_data[i*DW +: DW]  = d;
        bus.req_id[i*IW +: IW]    = id;
        bus.req_int[i]            = in;
    endtask

    task automatic clear_reqs;
        bus.req_valid = '0;
    endtask

    logic [3:0]  exp_rdy3  [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [2:0]  exp_id3   [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [31:0] exp_dat3  [5] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h100};
    logic        exp_int3  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_id    = '0;
        bus.req_int   = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + i, 3'(i + 1), 1'b0);

        // reset held two cycles with every requester valid
        for (int c = 0; c < 2; c++) begin
            tick;
            check("rst_ready",     32'(bus.req_ready), 32'h0);
            check("rst_cdb_valid", 32'(bus.cdb_valid), 32'h0);
            check("rst_cdb_id",    32'(bus.cdb_id),    32'h0);
            check("rst_cnt",       32'(bcast_cnt),     32'h0);
            check("rst_err",       32'(err_zero_id),   32'h0);
        end
        rst = 1'b0;
        clear_reqs;

        // single requester 1
        set_req(1, 1'b1, 32'hDEADBEEF, 3'd3, 1'b0);
        #1;
        check("t2_ready", 32'(bus.req_ready), 32'h2);
        tick;
        clear_reqs;
        check("t2_valid", 32'(bus.cdb_valid), 32'h1);
        check("t2_data",  bus.cdb_data,       32'hDEADBEEF);
        check("t2_id",    32'(bus.cdb_id),    32'h3);
        check("t2_int",   32'(bus.cdb_int),   32'h0);
        check("t2_cnt",   32'(bcast_cnt),     32'h1);
        tick;
        check("t2_idle_valid", 32'(bus.cdb_valid), 32'h0);
        check("t2_idle_id",    32'(bus.cdb_id),    32'h0);
        check("t2_idle_data",  bus.cdb_data,       32'h0);
        check("t2_idle_cnt",   32'(bcast_cnt),     32'h1);

        // restart from rr_ptr=0, all four continuously valid
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + i, 3'(i + 1), (i == 2));
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_ready", 32'(bus.req_ready), 32'(exp_rdy3[k]));
            tick;
            check("t3_valid", 32'(bus.cdb_valid), 32'h1);
            check("t3_id",    32'(bus.cdb_id),    32'(exp_id3[k]));
            check("t3_data",  bus.cdb_data,       exp_dat3[k]);
            check("t3_int",   32'(bus.cdb_int),   32'(exp_int3[k]));
        end
        check("t3_cnt", 32'(bcast_cnt), 32'd5);
        clear_reqs;

        // grant req2 so rr_ptr=3, then req0+req3 -> wrap order 3 then 0
        set_req(2, 1'b1, 32'h200, 3'd5, 1'b0);
        #1;
        check("t4_pre_ready", 32'(bus.req_ready), 32'h4);
        tick;
        check("t4_pre_id", 32'(bus.cdb_id), 32'h5);
        clear_reqs;
        set_req(0, 1'b1, 32'h300, 3'd6, 1'b0);
        set_req(3, 1'b1, 32'h303, 3'd7, 1'b1);
        #1;
        check("t4_ready_wrap", 32'(bus.req_ready), 32'h8);
        tick;
        check("t4_id_first", 32'(bus.cdb_id),  32'h7);
        check("t4_int_first", 32'(bus.cdb_int), 32'h1);
        bus.req_valid[3] = 1'b0;
        #1;
        check("t4_ready_next", 32'(bus.req_ready), 32'h1);
        tick;
        check("t4_id_second", 32'(bus.cdb_id), 32'h6);
        check("t4_data_second", bus.cdb_data, 32'h300);
        check("t4_cnt", 32'(bcast_cnt), 32'd8);
        clear_reqs;

        // tag 0 from req2: consumed, not broadcast, sticky error
        set_req(2, 1'b1, 32'hAAAA, 3'd0, 1'b0);
        #1;
        check("t5_ready", 32'(bus.req_ready), 32'h4);
        tick;
        clear_reqs;
        check("t5_valid", 32'(bus.cdb_valid), 32'h0);
        check("t5_id",    32'(bus.cdb_id),    32'h0);
        check("t5_err",   32'(err_zero_id),   32'h1);
        check("t5_cnt",   32'(bcast_cnt),     32'd8);
        tick;
        check("t5_err_sticky", 32'(err_zero_id), 32'h1);

        // flush with req0 and req3 valid while rr_ptr=3
        set_req(0, 1'b1, 32'h55, 3'd1, 1'b0);
        set_req(3, 1'b1, 32'h66, 3'd4, 1'b0);
        flush = 1'b1;
        #1;
        check("t6_flush_ready", 32'(bus.req_ready), 32'h0);
        tick;
        flush = 1'b0;
        check("t6_flush_valid", 32'(bus.cdb_valid), 32'h0);
        #1;
        check("t6_restart_ready", 32'(bus.req_ready), 32'h1);
        tick;
        check("t6_grant_valid", 32'(bus.cdb_valid), 32'h1);
        check("t6_grant_id",    32'(bus.cdb_id),    32'h1);
        check("t6_grant_data",  bus.cdb_data,       32'h55);
        check("t6_cnt",         32'(bcast_cnt),     32'd9);
        bus.req_valid[0] = 1'b0;
        flush = 1'b1;
        #1;
        check("t6_flush2_ready", 32'(bus.req_ready), 32'h0);
        check("t6_visible_valid", 32'(bus.cdb_valid), 32'h1);
        check("t6_visible_id",    32'(bus.cdb_id),    32'h1);
        tick;
        flush = 1'b0;
        check("t6_cleared_valid", 32'(bus.cdb_valid), 32'h0);
        check("t6_cleared_id",    32'(bus.cdb_id),    32'h0);
        check("t6_cleared_cnt",   32'(bcast_cnt),     32'd9);
        #1;
        check("t6_after_ready", 32'(bus.req_ready), 32'h8);

        // rst and flush together: rst wins and clears error and counter
        rst   = 1'b1;
        flush = 1'b1;
        #1;
        check("t7_ready", 32'(bus.req_ready), 32'h0);
        tick;
        rst   = 1'b0;
        flush = 1'b0;
        check("t7_err",   32'(err_zero_id),   32'h0);
        check("t7_cnt",   32'(bcast_cnt),     32'h0);
        check("t7_valid", 32'(bus.cdb_valid), 32'h0);
        #1;
        check("t7_reoffer_ready", 32'(bus.req_ready), 32'h8);
        tick;
        check("t7_reoffer_id",  32'(bus.cdb_id), 32'h4);
        check("t7_reoffer_cnt", 32'(bcast_cnt),  32'h1);
        clear_reqs;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
